msk_iq_split: RTL
=================

MSK_IQ_SPLIT -- requirements
Module: msk_iq_split

Interface
REQ-001 Parameter BIT_LEN, 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 Parameter DIFF_EN, 1: 1 enables differential precoding, 0 bypasses it.
REQ-003 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run enable from control.
REQ-007 din  input  1  serial data bit from the source.
REQ-008 din_valid  input  1  din holds a valid bit.
REQ-009 din_ready  output  1  block accepts din this cycle; this output is combinational.
REQ-010 clr_underrun  input  1  clears the underrun flag.
REQ-011 b_i  output  1  I-branch bit to the DDS modulator, registered.
REQ-012 b_q  output  1  Q-branch bit to the DDS modulator, registered.
REQ-013 bit_strobe  output  1  one-cycle pulse marking each bit boundary, registered.
REQ-014 active  output  1  high while the state machine is in RUN.
REQ-015 underrun  output  1  sticky flag set when a bit boundary occurs with no data.

Function
REQ-016 The state machine SHALL have two states:
- IDLE: active=0, b_i=b_q=0, bit counter held at 0.
- RUN: active=1.
REQ-017 In IDLE, din_ready SHALL equal en.
REQ-018 In IDLE, an accepted bit (din_valid & din_ready) SHALL cause all of the following:
- transition to RUN;
- bit counter cleared to 0;
- parity set to I.
REQ-019 In RUN, the bit counter SHALL count 0..BIT_LEN-1 and wrap to 0.
REQ-020 A boundary cycle is a RUN cycle with counter==BIT_LEN-1.
REQ-021 In RUN, din_ready SHALL be high only in a boundary cycle with en=1.
REQ-022 Each accepted bit d SHALL be precoded to e = d XOR e_prev when DIFF_EN=1, and to e = d otherwise.
REQ-023 e_prev SHALL be 0 after reset and after each entry to IDLE.
REQ-024 Even-indexed bits (k=0,2,...) SHALL load b_i and odd-indexed bits SHALL load b_q.
REQ-025 The loaded bit SHALL appear on the output on the clock edge following acceptance, so latency is 1 cycle.
REQ-026 Each of b_i and b_q SHALL hold for 2*BIT_LEN cycles, with b_q offset by BIT_LEN from b_i (staggered, MSK).
REQ-027 Underrun: a boundary cycle with en=1 and din_valid=0 SHALL cause both of the following:
- bit 0 is inserted in place of d and precoded and split as normal;
- underrun is set on the next edge.
REQ-028 underrun SHALL stay set until clr_underrun is high.
REQ-029 If clr_underrun and a new underrun occur in the same cycle, the set SHALL win.
REQ-030 A boundary cycle with en=0 SHALL cause all of the following on the next edge:
- transition to IDLE;
- b_i=b_q=0;
- no bit is consumed.
REQ-031 Deasserting en mid-bit SHALL NOT truncate the current bit; it SHALL take effect only at the next boundary.
REQ-032 bit_strobe SHALL pulse on the edge after every IDLE acceptance and after every RUN boundary cycle that stays in RUN.
REQ-033 din SHALL be sampled only when din_ready is high; din_valid without din_ready SHALL have no effect.

Reset
REQ-034 While reset=0, all of the following SHALL hold asynchronously:
- state=IDLE, counter=0, parity=I, e_prev=0;
- b_i=0, b_q=0, bit_strobe=0, active=0, underrun=0.
REQ-035 Reset asserted mid-bit SHALL abandon the current bit.
REQ-036 After reset is released, the first accepted bit SHALL restart at parity I.

Structure
REQ-037 The state encoding (IDLE/RUN) and parity constants SHALL be placed in the shared package msk_pkg.
REQ-038 The bit counter SHALL be a sub-module named msk_bit_timer with the following ports:
- inputs: clk, reset, run, sync_clr;
- outputs: boundary, count.
REQ-039 All remaining logic SHALL reside in msk_iq_split.

Verification
All scenarios use BIT_LEN=4.
REQ-040 Reset: hold reset=0 with din_valid=1 and en=1 -> all outputs remain 0 and din_ready=0 is not required.
REQ-041 Split, DIFF_EN=0, continuous valid, bits 1,0,1,1 -> b_i=1 for cycles 1-8, b_q=0 for cycles 5-12, b_i=1 from cycle 9, b_q=1 from cycle 13, with bit_strobe every 4 cycles.
REQ-042 Precoding, DIFF_EN=1, bits 1,1,0,0 -> encoded bits 1,0,0,0, so b_i=1, then b_q=0, then b_i=0, then b_q=0.
REQ-043 Underrun: drop din_valid at the third boundary -> inserted bit 0 (DIFF_EN=0), underrun=1 one cycle later, and underrun stays set until a clr_underrun pulse clears it.
REQ-044 Stop: drop en at counter=1 -> the bit completes, then at the boundary state=IDLE, b_i=b_q=0, active=0, din_ready=0.
REQ-045 Async reset mid-bit: assert reset at counter=2 -> outputs zero immediately, and the next accepted bit drives b_i.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared type definitions for the MSK I/Q splitter: controller states and branch parity.
package msk_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    PAR_I = 1'b0,
    PAR_Q = 1'b1
  } parity_t;

endpackage

// File: rtl/msk_bit_timer.sv
// Bit-period counter: counts 0..BIT_LEN-1 while run is high, held at 0 otherwise.
module msk_bit_timer #(
  parameter int unsigned BIT_LEN = 16,
  parameter int unsigned CNT_W   = $clog2(BIT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             sync_clr,
  output logic             boundary,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_LEN - 1);

  assign boundary = run && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || sync_clr || boundary) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msk_iq_split.sv
// Serial-to-staggered I/Q bit splitter with optional differential precoding for an MSK DDS.
module msk_iq_split
  import msk_pkg::*;
#(
  parameter int unsigned BIT_LEN = 16,
  parameter bit          DIFF_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  input  logic clr_underrun,
  output logic b_i,
  output logic b_q,
  output logic bit_strobe,
  output logic active,
  output logic underrun
);

  localparam int unsigned CNT_W = $clog2(BIT_LEN);

  state_t           state;
  state_t           state_nxt;
  parity_t          parity;
  parity_t          load_par;
  logic             e_prev;
  logic             boundary;
  logic [CNT_W-1:0] count;
  logic             sync_clr;
  logic             vld_p0;
  logic             stop;
  logic             und_set;
  logic             d_sel;
  logic             enc_p0;
  logic             unused_count;

  function automatic logic precode(input logic d, input logic prev);
    return DIFF_EN ? (d ^ prev) : d;
  endfunction

  msk_bit_timer #(
    .BIT_LEN (BIT_LEN),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state == ST_RUN),
    .sync_clr (sync_clr),
    .boundary (boundary),
    .count    (count)
  );

  assign unused_count = ^count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    vld_p0    = 1'b0;
    stop      = 1'b0;
    sync_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        din_ready = en;
        if (en && din_valid) begin
          state_nxt = ST_RUN;
          vld_p0    = 1'b1;
          sync_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        // en is only honoured at the boundary so a running bit is never truncated
        if (boundary) begin
          if (en) begin
            din_ready = 1'b1;
            vld_p0    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            stop      = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A missing bit at a boundary is replaced by 0 and still precoded and split.
  assign d_sel    = din & din_valid;
  assign und_set  = (state == ST_RUN) && boundary && en && !din_valid;
  assign enc_p0   = precode(d_sel, e_prev);
  assign load_par = (state == ST_IDLE) ? PAR_I : parity;
  assign active   = (state == ST_RUN);

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_i        <= 1'b0;
      b_q        <= 1'b0;
      bit_strobe <= 1'b0;
      e_prev     <= 1'b0;
      parity     <= PAR_I;
      underrun   <= 1'b0;
    end else begin
      bit_strobe <= vld_p0;
      if (stop) begin
        b_i    <= 1'b0;
        b_q    <= 1'b0;
        e_prev <= 1'b0;
        parity <= PAR_I;
      end else if (vld_p0) begin
        e_prev <= enc_p0;
        if (load_par == PAR_I) begin
          b_i <= enc_p0;
        end else begin
          b_q <= enc_p0;
        end
        parity <= (load_par == PAR_I) ? PAR_Q : PAR_I;
      end
      if (und_set) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
